// File: rtl/complex_addsub_pkg.sv
// complex_addsub shared definitions: op encoding and default widths.
// Consumed by complex_addsub and complex_addsub_lane.
package complex_addsub_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    OP_ADD      = 2'd0,
    OP_SUB      = 2'd1,
    OP_ADD_HALF = 2'd2,
    OP_SUB_HALF = 2'd3
  } op_e;

endpackage

// File: rtl/complex_addsub_lane.sv
// One component of the complex add/sub: W+1-bit sum, then halve or limit.
// COMPLEX_ADDSUB_SAT_EN selects saturation instead of wrap on overflow.
module complex_addsub_lane
  import complex_addsub_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld1,
  input  logic                ld2,
  input  logic [1:0]          op,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] c,
  output logic                ovf
);

  logic signed [W:0]   ax, bx, sum_d, s1_sum;
  logic                sub, half_d, s1_half;
  logic signed [W-1:0] res;

  always_comb begin
    ax     = {a[W-1], a};
    bx     = {b[W-1], b};
    sub    = (op == OP_SUB) || (op == OP_SUB_HALF);
    half_d = (op == OP_ADD_HALF) || (op == OP_SUB_HALF);
    sum_d  = sub ? (ax - bx) : (ax + bx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sum  <= '0;
      s1_half <= 1'b0;
    end else if (ld1) begin
      s1_sum  <= sum_d;
      s1_half <= half_d;
    end
  end

  // Top two bits disagree -> the W+1-bit sum does not fit in W bits.
  assign ovf = !s1_half && (s1_sum[W] != s1_sum[W-1]);

  always_comb begin
    res = s1_sum[W-1:0];
    if (s1_half) begin
      res = s1_sum[W:1];
    end else if (ovf) begin
`ifdef COMPLEX_ADDSUB_SAT_EN
      res = s1_sum[W] ? {1'b1, {(W-1){1'b0}}}
                      : {1'b0, {(W-1){1'b1}}};
`else
      res = s1_sum[W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
    end else if (ld2) begin
      c <= res;
    end
  end

endmodule

// File: rtl/complex_addsub.sv
// Two-stage complex add/sub with valid/ready flow and overflow statistics.
// Build macro: COMPLEX_ADDSUB_SAT_EN (saturate ADD/SUB overflow; else wrap).
module complex_addsub
  import complex_addsub_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] c_re,
  output logic signed [W-1:0] c_im,
  output logic                ovf_sticky,
  output logic [CNT_W-1:0]    ovf_cnt,
  input  logic                ovf_clr
);

  logic s1_valid, s2_adv, ld1, ld2;
  logic ovf_re, ovf_im, ovf_ev;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !reset && (!s1_valid || s2_adv);
  assign ld1      = in_valid && in_ready;
  assign ld2      = s1_valid && s2_adv;
  assign ovf_ev   = ld2 && (ovf_re || ovf_im);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid  <= in_valid;
      if (s2_adv)   out_valid <= s1_valid;
    end
  end

  complex_addsub_lane #(.W(W)) u_re (
    .clk   (clk),
    .reset (reset),
    .ld1   (ld1),
    .ld2   (ld2),
    .op    (op),
    .a     (a_re),
    .b     (b_re),
    .c     (c_re),
    .ovf   (ovf_re)
  );

  complex_addsub_lane #(.W(W)) u_im (
    .clk   (clk),
    .reset (reset),
    .ld1   (ld1),
    .ld2   (ld2),
    .op    (op),
    .a     (a_im),
    .b     (b_im),
    .c     (c_im),
    .ovf   (ovf_im)
  );

  // A clear in the same cycle as an event restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= ovf_ev;
      ovf_cnt    <= ovf_ev ? CNT_W'(1) : '0;
    end else if (ovf_ev) begin
      ovf_sticky <= 1'b1;
      if (!(&ovf_cnt)) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_complex_addsub.sv
// Randomized + directed bench for complex_addsub against a queue model.
// Honors COMPLEX_ADDSUB_SAT_EN in the reference model.
module tb_complex_addsub;

  localparam int W     = 16;
  localparam int CNT_W = 8;
  localparam int MAXV  = 2**(W-1) - 1;
  localparam int MINV  = -(2**(W-1));

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [1:0]          op = 2'd0;
  logic signed [W-1:0] a_re = '0, a_im = '0;
  logic signed [W-1:0] b_re = '0, b_im = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] c_re, c_im;
  logic                ovf_sticky;
  logic [CNT_W-1:0]    ovf_cnt;
  logic                ovf_clr = 1'b0;

  complex_addsub #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a_re       (a_re),
    .a_im       (a_im),
    .b_re       (b_re),
    .b_im       (b_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_re       (c_re),
    .c_im       (c_im),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int re;
    int im;
    bit ovf;
  } exp_t;

  exp_t q[$];

  function automatic void comp(input logic [1:0] o, input int a, input int b,
                               output int r, output bit ov);
    int s;
    s  = o[0] ? a - b : a + b;
    ov = 1'b0;
    r  = s;
    if (o[1]) begin
      r = s >>> 1;
    end else if (s > MAXV || s < MINV) begin
      ov = 1'b1;
`ifdef COMPLEX_ADDSUB_SAT_EN
      r = (s > MAXV) ? MAXV : MINV;
`else
      r = (s > MAXV) ? s - 2**W : s + 2**W;
`endif
    end
  endfunction

  function automatic exp_t model(input logic [1:0] o, input int ar, input int ai,
                                 input int br, input int bi);
    exp_t e;
    bit   o1, o2;
    comp(o, ar, br, e.re, o1);
    comp(o, ai, bi, e.im, o2);
    e.ovf = o1 || o2;
    return e;
  endfunction

  // Monitor state: everything the DUT saw at the edge after the last negedge.
  bit         p_reset = 1'b1;
  bit         p_acc, p_hs, p_ov, p_clr;
  int         p_cre, p_cim;
  exp_t       p_exp;
  int         mcnt = 0;
  bit         msticky = 1'b0;
  int         n_out = 0;
  bit         saw_stall_in = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    bit   nb;
    if (p_reset) begin
      q.delete();
      mcnt    = 0;
      msticky = 1'b0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_c_re", int'(c_re), 0);
      chk("rst_c_im", int'(c_im), 0);
    end else begin
      if (p_acc) q.push_back(p_exp);
      nb = out_valid && (!p_ov || p_hs);
      if (nb) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("c_re", int'(c_re), e.re);
          chk("c_im", int'(c_im), e.im);
          if (p_clr) begin
            mcnt    = e.ovf ? 1 : 0;
            msticky = e.ovf;
          end else if (e.ovf) begin
            msticky = 1'b1;
            if (mcnt < 2**CNT_W - 1) mcnt++;
          end
        end
      end else if (p_clr) begin
        mcnt    = 0;
        msticky = 1'b0;
      end
      if (p_ov && !p_hs) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_c_re", int'(c_re), p_cre);
        chk("stall_c_im", int'(c_im), p_cim);
      end
    end
    chk("ovf_cnt", int'(ovf_cnt), mcnt);
    chk("ovf_sticky", int'(ovf_sticky), int'(msticky));
    if (in_valid && !in_ready && !reset) saw_stall_in = 1'b1;
    p_reset = reset;
    p_acc   = in_valid && in_ready && !reset;
    p_hs    = out_valid && out_ready;
    p_ov    = out_valid;
    p_clr   = ovf_clr;
    p_cre   = int'(c_re);
    p_cim   = int'(c_im);
    p_exp   = model(op, int'(a_re), int'(a_im), int'(b_re), int'(b_im));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] o, input int ar, input int ai,
                      input int br, input int bi);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    op = o;
    a_re = W'(ar);
    a_im = W'(ai);
    b_re = W'(br);
    b_im = W'(bi);
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid || dut.s1_valid) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 0, 1);
    tick();
  endtask

  function automatic int rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return MAXV;
      1:       return MINV;
      2:       return 0;
      default: return int'($signed(W'($urandom)));
    endcase
  endfunction

  initial begin
    int nb0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(in_ready), 1);
    chk("ovf_cnt_rst", int'(ovf_cnt), 0);
    tick();

    send(OPC(0), 100, -200, 50, 30);
    chk("lat_not_early", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(out_valid), 1);
    chk("add_re", int'(c_re), 150);
    chk("add_im", int'(c_im), -170);
    chk("add_cnt", int'(ovf_cnt), 0);
    drain();

    clr_pulse();
    send(OPC(0), 32767, 0, 1, 0);
    @(posedge clk);
    #1;
`ifdef COMPLEX_ADDSUB_SAT_EN
    chk("ovf_re_sat", int'(c_re), 32767);
`else
    chk("ovf_re_wrap", int'(c_re), -32768);
`endif
    chk("ovf_sticky1", int'(ovf_sticky), 1);
    chk("ovf_cnt1", int'(ovf_cnt), 1);
    drain();

    send(OPC(3), -32768, 0, 32767, 0);
    @(posedge clk);
    #1;
    chk("subh_re", int'(c_re), -32768);
    chk("subh_cnt", int'(ovf_cnt), 1);
    drain();

    nb0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(OPC(i % 4), rnd_opnd(), rnd_opnd(), rnd_opnd(), rnd_opnd());
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", n_out - nb0, 8);
    chk("stream_in_ready_drop", int'(saw_stall_in), 1);

    send(OPC(0), 32767, 0, 1, 0);
    send(OPC(1), 0, -32768, 0, 1);
    drain();
    send(OPC(0), 32767, 32767, 1, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    chk("clr_coinc_cnt", int'(ovf_cnt), 1);
    chk("clr_coinc_sticky", int'(ovf_sticky), 1);
    drain();

    clr_pulse();
    for (int i = 0; i < 300; i++) send(OPC(0), 32767, -32768, 32767, -1);
    drain();
    chk("cnt_saturate", int'(ovf_cnt), 255);

    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom);
      a_re      = W'(rnd_opnd());
      a_im      = W'(rnd_opnd());
      b_re      = W'(rnd_opnd());
      b_im      = W'(rnd_opnd());
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    drain();

    out_ready = 1'b0;
    send(OPC(0), 1, 2, 3, 4);
    send(OPC(1), 32767, 0, -1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_flight_valid", int'(out_valid), 0);
    chk("rst_flight_cnt", int'(ovf_cnt), 0);
    out_ready = 1'b1;
    nb0 = n_out;
    repeat (10) tick();
    chk("no_stale_beat", n_out - nb0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [1:0] OPC(input int i);
    return 2'(i);
  endfunction

endmodule

// File: doc/complex_addsub.md
COMPLEX_ADDSUB -- requirements
Module: complex_addsub

Interface
REQ-001 SHALL have parameter W, default 16, meaning signed width of each real/imag component in and out.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the overflow event counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port op  input  2  operation: ADD, SUB, ADD_HALF, SUB_HALF.
REQ-008 SHALL have ports a_re, a_im, b_re, b_im  input  W each  signed operands.
REQ-009 SHALL have port out_valid  output  1  result beat present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have ports c_re, c_im  output  W each  signed result.
REQ-012 SHALL have port ovf_sticky  output  1  set on any component overflow since the last clear.
REQ-013 SHALL have port ovf_cnt  output  CNT_W  count of overflowing beats, saturating at all-ones.
REQ-014 SHALL have port ovf_clr  input  1  clears ovf_sticky and ovf_cnt.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready; latency from accept to out_valid is exactly 2 cycles with no stall.
REQ-016 Stage 1 SHALL compute a±b per component at W+1 bits; stage 2 SHALL apply scaling/limiting and register c_re/c_im.
REQ-017 ADD_HALF/SUB_HALF SHALL produce the W+1-bit result arithmetically shifted right by 1 (floor); these ops never overflow.
REQ-018 ADD/SUB overflow SHALL be detected when the W+1-bit result does not fit in W bits, per component.
REQ-019 Each stage SHALL hold its data while its valid is set and downstream is not ready; in_ready = !s1_valid || s2 can advance; s2 advances when !out_valid || out_ready.
REQ-020 c_re/c_im/out_valid SHALL remain stable while out_valid && !out_ready; no beat is dropped or duplicated.
REQ-021 Full throughput SHALL be one beat per cycle when out_ready is held high.
REQ-022 An overflow SHALL update ovf_sticky/ovf_cnt when the beat enters stage 2; one increment per beat even if both components overflow.
REQ-023 ovf_clr coincident with an overflow event SHALL clear first then apply the event (ovf_sticky=1, ovf_cnt=1).
REQ-024 ovf_cnt SHALL hold at 2^CNT_W-1 on further events.

Reset
REQ-025 On reset: out_valid=0, internal valids=0, c_re=c_im=0, ovf_sticky=0, ovf_cnt=0; in-flight beats discarded.
REQ-026 in_ready SHALL be 1 in the cycle after reset deasserts; a beat presented during reset is not accepted.

Configuration
REQ-027 Macro COMPLEX_ADDSUB_SAT_EN defined: ADD/SUB overflow saturates to +2^(W-1)-1 or -2^(W-1) by sign of the W+1-bit result.
REQ-028 Macro COMPLEX_ADDSUB_SAT_EN undefined: ADD/SUB overflow wraps (low W bits kept); overflow flags/counter behave identically.

Structure
REQ-029 Package complex_addsub_pkg SHALL hold the 2-bit op encoding (ADD=0, SUB=1, ADD_HALF=2, SUB_HALF=3) and default W/CNT_W constants.
REQ-030 One sub-module, complex_addsub_lane, SHALL implement one component's add/sub, scale, limit and overflow flag; instantiated twice (re, im).

Verification
REQ-031 W=16, ADD (100,-200)+(50,30), out_ready=1 -> c=(150,-170) exactly 2 cycles after accept, ovf_cnt=0.
REQ-032 ADD re 32767+1: SAT_EN -> c_re=32767; no SAT_EN -> c_re=-32768; both -> ovf_sticky=1, ovf_cnt=1.
REQ-033 SUB_HALF re -32768-32767 -> c_re=-32768 (floor of -65535/2), no overflow flagged.
REQ-034 Stream 8 beats with out_ready low 3 cycles mid-stream -> in_ready drops, 8 results in order, outputs stable while stalled.
REQ-035 ovf_clr asserted in the cycle an overflowing beat enters stage 2 -> ovf_sticky=1, ovf_cnt=1; 300 overflowing beats with CNT_W=8 -> ovf_cnt=255.
REQ-036 reset asserted with 2 beats in flight -> next cycle out_valid=0, c=0, counters 0; no stale beat emerges afterwards.
